// File: rtl/gf2_poly_div_4bit.sv
// Carry-less GF(2) polynomial long divider, one quotient bit per clock.
// Recovers multiplier operands: dividend = quotient * divisor ^ remainder.
module gf2_poly_div_4bit #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-2:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic [N-1:0]   quotient,
    output logic [N-2:0]   remainder,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int DW = 2 * N - 1;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [DW-1:0] LEAD0 = DW'(1) << (N - 1);
    localparam logic [KW-1:0] KTOP = KW'(N - 1);

    typedef enum logic [0:0] {
        IDLE,
        CALC
    } state_t;

    state_t        state_q, state_n;
    logic [DW-1:0] r_q, r_n;
    logic [N-1:0]  d_q, d_n;
    logic [N-1:0]  q_q, q_n;
    logic [KW-1:0] k_q, k_n;
    logic [N-1:0]  quot_n;
    logic [N-2:0]  rem_n;
    logic          done_n;
    logic          err_n;

    // Divisor aligned to the current step and the dividend bit it cancels.
    logic [DW-1:0] d_shift;
    logic [DW-1:0] lead_mask;
    logic          lead;

    assign d_shift   = DW'(d_q) << k_q;
    assign lead_mask = LEAD0 << k_q;
    assign lead      = |(r_q & lead_mask);
    assign busy      = (state_q == CALC);

    // State and result registers; results only move on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            r_q       <= '0;
            d_q       <= '0;
            q_q       <= '0;
            k_q       <= '0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_n;
            r_q       <= r_n;
            d_q       <= d_n;
            q_q       <= q_n;
            k_q       <= k_n;
            quotient  <= quot_n;
            remainder <= rem_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

    // Next-state: accept or reject a request, then one XOR step per cycle.
    always_comb begin
        state_n = state_q;
        r_n     = r_q;
        d_n     = d_q;
        q_n     = q_q;
        k_n     = k_q;
        quot_n  = quotient;
        rem_n   = remainder;
        done_n  = 1'b0;
        err_n   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor[N-1]) begin
                        r_n     = dividend;
                        d_n     = divisor;
                        q_n     = '0;
                        k_n     = KTOP;
                        state_n = CALC;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            CALC: begin
                if (lead) begin
                    r_n      = r_q ^ d_shift;
                    q_n[k_q] = 1'b1;
                end else begin
                    q_n[k_q] = 1'b0;
                end
                if (k_q == '0) begin
                    state_n = IDLE;
                    quot_n  = q_n;
                    rem_n   = r_n[N-2:0];
                    done_n  = 1'b1;
                end else begin
                    k_n = k_q - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/gf2_poly_div_4bit.md
# gf2_poly_div_4bit

Sequential binary-polynomial (GF(2), carry-less) long divider: the inverse of the team's overlap-free Karatsuba 4-bit polynomial multiplier. It takes a (2N-1)-bit product polynomial and a monic N-bit divisor polynomial, and returns the quotient and remainder with a start/busy/done handshake. Its purpose is to check and recover multiplier operands in self-test and reduction paths, one quotient bit per clock.

## Interface
- N, default 4: operand width. Dividend is 2N-1 bits, divisor N bits, quotient N bits, remainder N-1 bits.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only while busy=0.
- dividend  input  2N-1  product polynomial; bit i is the coefficient of x^i.
- divisor  input  N  divisor polynomial; must be monic (divisor[N-1]=1).
- quotient  output  N  result quotient; registered.
- remainder  output  N-1  result remainder; registered.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when quotient and remainder update.
- err  output  1  one-cycle pulse when a start is rejected for a non-monic divisor.

## Operation
- Reset values: quotient=0, remainder=0, busy=0, done=0, err=0, state IDLE, internal registers zero.
- States:
  - IDLE: not busy.
  - CALC: iterating, busy=1, down-counter k running from N-1 to 0.
- IDLE with start=1 and divisor[N-1]=1:
  - Latch dividend into working register R (2N-1 bits) and divisor into D.
  - Clear the working quotient Q; set k=N-1.
  - Go to CALC with busy=1.
- IDLE with start=1 and divisor[N-1]=0 (this includes divisor=0):
  - err=1 for one cycle.
  - Stay in IDLE; quotient and remainder are unchanged; busy stays 0.
- CALC, each cycle:
  - If R[N-1+k]=1: R ^= D<<k and Q[k]=1; otherwise Q[k]=0.
  - When k=0, go to IDLE. On the same edge load quotient=final Q and remainder=R[N-2:0], set done=1, clear busy.
- All arithmetic is XOR only; there are no carries. Bits R[2N-2:N-1] are zero after the final step.
- quotient and remainder hold the previous result for the whole CALC period. They change only on the completion edge.
- start is ignored while busy=1. There is no queueing.
- done and err are never high in the same cycle.
- rst=1 in any state, including mid-CALC, forces the reset values on the next edge. A partial result is never reported.

## Timing
- Latency: start sampled at edge E0; busy=1 from after E0; N CALC edges E1..EN.
- busy=0, done=1 and the new results are visible after EN. For N=4 that is 4 clocks from start to done.
- done lasts exactly one cycle and clears at EN+1 unless another completion occurs.
- Back-to-back operation: start may be asserted in the cycle done=1, because busy=0 then. The sustained rate is one division per N clocks.
- err is asserted the cycle after the rejected start edge and lasts one cycle.
- dividend and divisor only need to be valid in the start cycle. Later changes to them have no effect.

## Test plan
- Exact inverse of the multiplier case (13 times 10 carry-less = 0x72): dividend=0x72 (1110010), divisor=13 (1101), start pulse → 4 clocks later done=1, quotient=10 (1010), remainder=0.
- Swapped divisor: dividend=0x72, divisor=10 (1010) → quotient=13, remainder=0.
  - Then dividend=0x7F, divisor=11 (1011) issued back-to-back in the done cycle → 4 clocks later quotient=13, remainder=0.
- Nonzero remainder: dividend=0x73, divisor=13 → quotient=10, remainder=1 (001).
  - Also dividend=0x05, divisor=8 → quotient=0, remainder=5.
- Rejected divisors: divisor=5 (0101) with start → err=1 for one cycle, busy stays 0, quotient and remainder keep their prior values. Repeat with divisor=0.
- Start while busy: a second start with different operands 2 cycles into CALC → ignored; the first result is reported at the original time and only one done pulse occurs.
- Reset mid-operation: rst=1 during the 3rd CALC cycle → next edge busy=0, done=0, quotient=0, remainder=0, and no done pulse follows. A subsequent start then completes normally.
